// File: rtl/riscv_dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the core load/store port and a debug/loader port.
// Optional `DMEM_ARB_CPU_PRIO_EN` selects fixed cpu priority instead of round-robin arbitration.
module riscv_dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_cmd_t;

  state_t             state, state_n;
  mem_cmd_t           cmd_n;
  logic               mem_en_n;
  logic               cpu_ack_n, dbg_ack_n;
  logic [DATA_W-1:0]  cpu_rdata_n, dbg_rdata_n;
  logic               gnt_dbg, gnt_dbg_n;
  logic               rd, rd_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               pick_dbg;

`ifdef DMEM_ARB_CPU_PRIO_EN
  // dbg only wins when the core is not asking.
  assign pick_dbg = dbg_req & ~cpu_req;
`else
  logic last_cpu, last_cpu_n;

  // On contention serve the port that did not win last time.
  assign pick_dbg = dbg_req & (~cpu_req | last_cpu);
`endif

  assign cpu_stall = cpu_req & ~cpu_ack;

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      gnt_dbg   <= 1'b0;
      rd        <= 1'b0;
      cnt       <= '0;
`ifndef DMEM_ARB_CPU_PRIO_EN
      last_cpu  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      mem_en    <= mem_en_n;
      mem_we    <= cmd_n.we;
      mem_addr  <= cmd_n.addr;
      mem_wdata <= cmd_n.wdata;
      mem_wstrb <= cmd_n.wstrb;
      cpu_ack   <= cpu_ack_n;
      dbg_ack   <= dbg_ack_n;
      cpu_rdata <= cpu_rdata_n;
      dbg_rdata <= dbg_rdata_n;
      gnt_dbg   <= gnt_dbg_n;
      rd        <= rd_n;
      cnt       <= cnt_n;
`ifndef DMEM_ARB_CPU_PRIO_EN
      last_cpu  <= last_cpu_n;
`endif
    end
  end

  // Next-state and next-output logic; mem_* are only non-zero during ISSUE.
  always_comb begin
    state_n     = state;
    mem_en_n    = 1'b0;
    cmd_n       = '0;
    cpu_ack_n   = 1'b0;
    dbg_ack_n   = 1'b0;
    cpu_rdata_n = cpu_rdata;
    dbg_rdata_n = dbg_rdata;
    gnt_dbg_n   = gnt_dbg;
    rd_n        = rd;
    cnt_n       = cnt;
`ifndef DMEM_ARB_CPU_PRIO_EN
    last_cpu_n  = last_cpu;
`endif
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_n   = ISSUE;
          mem_en_n  = 1'b1;
          gnt_dbg_n = pick_dbg;
`ifndef DMEM_ARB_CPU_PRIO_EN
          last_cpu_n = ~pick_dbg;
`endif
          if (pick_dbg) begin
            cmd_n.we    = dbg_we;
            cmd_n.addr  = dbg_addr;
            cmd_n.wdata = dbg_wdata;
            cmd_n.wstrb = '1;
          end else begin
            cmd_n.we    = cpu_we;
            cmd_n.addr  = cpu_addr;
            cmd_n.wdata = cpu_wdata;
            cmd_n.wstrb = cpu_wstrb;
          end
          rd_n = ~cmd_n.we;
        end
      end
      ISSUE: begin
        if (rd) begin
          state_n = WAIT;
          cnt_n   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_n   = RESP;
          cpu_ack_n = ~gnt_dbg;
          dbg_ack_n = gnt_dbg;
        end
      end
      WAIT: begin
        // Read data is valid in the last WAIT cycle; capture it with the ack.
        if (cnt == '0) begin
          state_n   = RESP;
          cpu_ack_n = ~gnt_dbg;
          dbg_ack_n = gnt_dbg;
          if (gnt_dbg) dbg_rdata_n = mem_rdata;
          else         cpu_rdata_n = mem_rdata;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Scoreboarded bench for riscv_dmem_arbiter; instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
// Both instances share the request inputs; each instance has its own behavioural RAM.
module tb_riscv_dmem_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        load_mem = 1'b1;

  logic        a_cpu_ack, a_cpu_stall, a_dbg_ack, a_mem_en, a_mem_we;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_cpu_ack, b_cpu_stall, b_dbg_ack, b_mem_en, b_mem_we;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  int checks = 0;
  int errors = 0;
  logic [32:0] cpu_q[$];
  logic [32:0] dbg_q[$];
  int          order_q[$];

  always #5 clock = ~clock;

  riscv_dmem_arbiter #(.ADDR_W(32), .MEM_LAT(1)) u_a (
    .clock(clock), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata)
  );

  riscv_dmem_arbiter #(.ADDR_W(32), .MEM_LAT(3)) u_b (
    .clock(clock), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
  );

  // Synchronous RAMs; read data is valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] pa, pb0, pb1, pb2;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 32'h0;
      mem_a[4] <= 32'hDEAD_BEEF;
      mem_a[9] <= 32'h1122_3344;
    end else if (a_mem_en && a_mem_we) begin
      for (int k = 0; k < 4; k++)
        if (a_mem_wstrb[k]) mem_a[a_mem_addr[7:2]][k*8 +: 8] <= a_mem_wdata[k*8 +: 8];
    end
    pa <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:2]] : JUNK;
  end
  assign a_mem_rdata = pa;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 32'h0;
      mem_b[8] <= 32'hCAFE_F00D;
    end else if (b_mem_en && b_mem_we) begin
      for (int k = 0; k < 4; k++)
        if (b_mem_wstrb[k]) mem_b[b_mem_addr[7:2]][k*8 +: 8] <= b_mem_wdata[k*8 +: 8];
    end
    pb0 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:2]] : JUNK;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign b_mem_rdata = pb2;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b0;
    cpu_req = 1'b1;
    #1;
    checks++;
    if ({a_cpu_ack, a_dbg_ack, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb,
         a_cpu_rdata, a_dbg_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b ack=%b/%b addr=%h rdata=%h/%h, required all zero",
               a_mem_en, a_cpu_ack, a_dbg_ack, a_mem_addr, a_cpu_rdata, a_dbg_rdata);
    end
    checks++;
    if (a_cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_req: got %b required 1", a_cpu_stall);
    end
    cpu_req = 1'b0;
    #1;
    checks++;
    if (a_cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle: got %b required 0", a_cpu_stall);
    end
    idle(2);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_cpu_read();
    logic [32:0] e;
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    cpu_q.push_back({1'b1, 32'hDEAD_BEEF});
    #1;
    checks++;
    if (a_cpu_stall !== 1'b1) begin
      errors++; $display("FAIL rd_stall_cyc0: got %b required 1", a_cpu_stall);
    end
    cyc();
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h10 || a_cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rd_issue_cyc1: en=%b we=%b addr=%h stall=%b required 1 0 00000010 1",
               a_mem_en, a_mem_we, a_mem_addr, a_cpu_stall);
    end
    cyc();
    checks++;
    if (a_mem_en !== 1'b0 || a_cpu_ack !== 1'b0 || a_cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rd_wait_cyc2: en=%b ack=%b stall=%b required 0 0 1", a_mem_en, a_cpu_ack, a_cpu_stall);
    end
    cyc();
    checks++;
    if (a_cpu_ack !== 1'b1 || a_cpu_stall !== 1'b0 || cpu_q.size() == 0) begin
      errors++;
      $display("FAIL rd_ack_cyc3: ack=%b stall=%b required 1 0", a_cpu_ack, a_cpu_stall);
    end else begin
      e = cpu_q.pop_front();
      if (a_cpu_rdata !== e[31:0]) begin
        errors++; $display("FAIL rd_data: got %h required %h", a_cpu_rdata, e[31:0]);
      end
    end
    cpu_req = 1'b0;
    cyc();
    checks++;
    if (a_cpu_ack !== 1'b0 || a_cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_hold: ack=%b rdata=%h required 0 deadbeef", a_cpu_ack, a_cpu_rdata);
    end
    idle(5);
  endtask

  task automatic test_dbg_write();
    logic [32:0] e;
    dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678; dbg_req = 1'b1;
    dbg_q.push_back({1'b0, 32'h0});
    cyc();
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_wstrb !== 4'hF ||
        a_mem_wdata !== 32'h1234_5678 || a_mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL dbg_wr_issue: en=%b we=%b strb=%h wdata=%h addr=%h required 1 1 f 12345678 00000020",
               a_mem_en, a_mem_we, a_mem_wstrb, a_mem_wdata, a_mem_addr);
    end
    dbg_req = 1'b0;
    cyc();
    checks++;
    if (a_dbg_ack !== 1'b1 || a_cpu_ack !== 1'b0 || dbg_q.size() == 0) begin
      errors++;
      $display("FAIL dbg_wr_ack: dbg_ack=%b cpu_ack=%b required 1 0", a_dbg_ack, a_cpu_ack);
    end else begin
      e = dbg_q.pop_front();
      if (e[32] !== 1'b0) begin
        errors++; $display("FAIL dbg_wr_kind: got read entry required write");
      end
    end
    cyc();
    checks++;
    if (a_dbg_ack !== 1'b0 || a_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL dbg_wr_single_pulse: ack=%b en=%b required 0 0", a_dbg_ack, a_mem_en);
    end
    idle(4);
  endtask

  task automatic test_cpu_write_strobe();
    logic [32:0] e;
    bit          got;
    cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'hAABB_CCDD; cpu_wstrb = 4'b0011; cpu_req = 1'b1;
    cyc();
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_wstrb !== 4'b0011 || a_mem_addr !== 32'h24) begin
      errors++;
      $display("FAIL cpu_wr_issue: en=%b strb=%b addr=%h required 1 0011 00000024",
               a_mem_en, a_mem_wstrb, a_mem_addr);
    end
    cyc();
    checks++;
    if (a_cpu_ack !== 1'b1 || a_dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_ack: cpu_ack=%b dbg_ack=%b required 1 0", a_cpu_ack, a_dbg_ack);
    end
    cpu_req = 1'b0;
    idle(2);
    cpu_we = 1'b0; cpu_req = 1'b1;
    cpu_q.push_back({1'b1, 32'h1122_CCDD});
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      cyc();
      if (a_dbg_ack === 1'b1) begin
        checks++; errors++; $display("FAIL cpu_wr_stray_dbg_ack: got 1 required 0");
      end
      if (a_cpu_ack === 1'b1) begin
        got = 1'b1;
        e = cpu_q.pop_front();
        checks++;
        if (a_cpu_rdata !== e[31:0]) begin
          errors++; $display("FAIL strobe_readback: got %h required %h", a_cpu_rdata, e[31:0]);
        end
      end
    end
    cpu_req = 1'b0;
    if (!got) begin
      checks++; errors++; $display("FAIL strobe_readback_timeout: got no ack required ack");
    end
    idle(6);
  endtask

  task automatic test_arbitration();
    int acks;
    int p;
    do_reset();
`ifdef DMEM_ARB_CPU_PRIO_EN
    order_q = '{0, 0, 0, 1};
`else
    order_q = '{0, 1, 0, 1};
`endif
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hC0C0_C0C0; cpu_wstrb = 4'hF;
    dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hD0D0_D0D0;
    cpu_req = 1'b1; dbg_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      cyc();
      if (a_cpu_ack === 1'b1 && a_dbg_ack === 1'b1) begin
        checks++; errors++; $display("FAIL arb_double_ack: both acks high in one cycle");
      end
      if (a_mem_en === 1'b1 && order_q.size() > 0) begin
        checks++;
        if (a_mem_addr !== (order_q[0] == 1 ? 32'h44 : 32'h40)) begin
          errors++;
          $display("FAIL arb_grant_addr: got %h required %h", a_mem_addr,
                   (order_q[0] == 1 ? 32'h44 : 32'h40));
        end
      end
      if ((a_cpu_ack === 1'b1 || a_dbg_ack === 1'b1) && order_q.size() > 0) begin
        p = order_q.pop_front();
        acks++;
        checks++;
        if ((p == 1) !== (a_dbg_ack === 1'b1)) begin
          errors++;
          $display("FAIL arb_order_%0d: got %s required %s", acks,
                   a_dbg_ack ? "dbg" : "cpu", p == 1 ? "dbg" : "cpu");
        end
        if (acks == 3) cpu_req = 1'b0;
        if (acks == 4) dbg_req = 1'b0;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    if (acks < 4) begin
      checks++; errors++; $display("FAIL arb_timeout: got %0d acks required 4", acks);
    end
    idle(8);
  endtask

  task automatic test_reset_in_flight();
    bit cpu_seen;
    do_reset();
    idle(1);
    dbg_we = 1'b0; dbg_addr = 32'h20; dbg_req = 1'b1;
    cyc();
    checks++;
    if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h20) begin
      errors++; $display("FAIL flight_issue: en=%b addr=%h required 1 00000020", b_mem_en, b_mem_addr);
    end
    cyc();
    rst = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h5555_AAAA; cpu_wstrb = 4'hF; cpu_req = 1'b1;
    dbg_we = 1'b1; dbg_addr = 32'h34; dbg_wdata = 32'h0F0F_0F0F;
    #1;
    checks++;
    if ({b_cpu_ack, b_dbg_ack, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wstrb,
         b_cpu_rdata, b_dbg_rdata} !== '0 || b_cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL flight_reset_outputs: en=%b ack=%b/%b addr=%h stall=%b required zeros, stall 1",
               b_mem_en, b_cpu_ack, b_dbg_ack, b_mem_addr, b_cpu_stall);
    end
    idle(2);
    rst = 1'b1;
    cpu_seen = 1'b0;
    for (int c = 0; c < 20 && !cpu_seen; c++) begin
      cyc();
      if (b_dbg_ack === 1'b1) begin
        checks++; errors++; $display("FAIL flight_dbg_first: got dbg_ack required cpu_ack first");
      end
      if (b_cpu_ack === 1'b1) begin
        cpu_seen = 1'b1;
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
    end
    checks++;
    if (!cpu_seen) begin
      errors++; $display("FAIL flight_cpu_timeout: got no cpu_ack required one");
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (b_dbg_ack === 1'b1 || b_cpu_ack === 1'b1) begin
        checks++; errors++;
        $display("FAIL flight_stale_ack: cpu_ack=%b dbg_ack=%b required 0 0", b_cpu_ack, b_dbg_ack);
      end
    end
    checks++;
    if (b_mem_en !== 1'b0) begin
      errors++; $display("FAIL flight_quiet: en=%b required 0", b_mem_en);
    end
  endtask

  initial begin
    #2;
    rst = 1'b0;
    idle(3);
    load_mem = 1'b0;
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_cpu_write_strobe();
    test_arbitration();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
